uart_rx_frame: RTL and testbench

Parametrised UART receiver for serial-in/parallel-out paths running on a single `rx_clk`. It supports configurable data width and stop-bit count, optional parity, and 3-sample majority voting. Received words are delivered through a valid/ready handshake and carry per-word error flags. It sits between the pad-side serial input and the byte-consuming logic.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_rx_frame.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, legal parameter ranges and
// the counter-width helper used by both the receiver and the transmitter.
// Pure declarations; no clocked logic, so no latency or backpressure.
package uart_pkg;

  // State encoding, kept as plain localparams so a TX FSM can reuse codes.
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } uart_state_e;

  // Legal parameter ranges.
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line front end: 2-flop synchroniser (resets to idle-high) plus the
// two mid-bit sample flops and the 2-of-3 majority vote. Latency: 2 cycles
// rx_in -> line; vote is combinational on the third sample. No backpressure.
// Ports: rx_clk/rx_rst clock and sync reset; rx_in raw line; samp0_en/samp1_en
//        capture the first/second vote samples; line synchronised value;
//        vote majority of the two captured samples and the current line.
module uart_rx_sync (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic rx_in,
  input  logic samp0_en,
  input  logic samp1_en,
  output logic line,
  output logic vote
);

  logic meta_q;
  logic line_q;
  logic samp0_q;
  logic samp1_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      meta_q  <= 1'b1;
      line_q  <= 1'b1;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      line_q <= meta_q;
      if (samp0_en) samp0_q <= line_q;
      if (samp1_en) samp1_q <= line_q;
    end
  end

  assign line = line_q;
  assign vote = maj3(samp0_q, samp1_q, line_q);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start/data/[parity]/stop framing with 3-sample voting.
// Latency: word published at the mid-point of the last stop bit (+2 sync).
// Backpressure: rx_valid held until rx_ready; a new word overwrites and flags rx_overrun.
// Ports: rx_clk, rx_rst (sync, active-high); rx_in serial line (idle 1);
//        rx_ready consumer accept; rx_out/rx_valid word and valid;
//        rx_frame_err, rx_parity_err, rx_overrun per-word flags; rx_busy FSM active.
// Build option: define UART_RX_PARITY_EN to expect a parity bit after the data.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW   = cnt_width(CLKS_PER_BIT);
  localparam int BW   = cnt_width(DATA_BITS);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_p_q, frame_p_d;
  // Cleared after a break so a held-low line cannot retrigger start detection.
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  logic line;
  logic vote;
  logic dec;
  logic last;
  logic pub;
  logic pub_fe;

  uart_rx_sync u_sync (
    .rx_clk   (rx_clk),
    .rx_rst   (rx_rst),
    .rx_in    (rx_in),
    .samp0_en (cnt_q == CNT_S0),
    .samp1_en (cnt_q == CNT_S1),
    .line     (line),
    .vote     (vote)
  );

`ifdef UART_RX_PARITY_EN
  logic par_p_q, par_p_d;
  logic pe_q, pe_d;
`endif

  assign dec  = (cnt_q == CNT_DEC);
  assign last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = last ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    frame_p_d = frame_p_q;
    armed_d   = armed_q;
    pub       = 1'b0;
    // Frame flag for a word published this cycle includes the final stop vote.
    pub_fe    = frame_p_q | ~vote;
`ifdef UART_RX_PARITY_EN
    par_p_d   = par_p_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!armed_q) begin
          if (line) armed_d = 1'b1;
        end else if (!line) begin
          // This cycle is count 0 of the start bit.
          state_d   = ST_START;
          cnt_d     = CW'(1);
          frame_p_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_p_d   = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (dec && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (dec) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (last) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            stop_d = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (dec) par_p_d = vote ^ (^shreg_q) ^ (PARITY_ODD != 0);
        if (last) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (dec) begin
          if (!vote) frame_p_d = 1'b1;
          if (stop_q == STOP_LAST) begin
            // Publish at mid-bit so a following start edge is not missed.
            pub     = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (pub_fe && (shreg_q == '0)) armed_d = 1'b0;
          end
        end else if (last) begin
          stop_d = stop_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output word register: publish wins over accept; overrun only when the
  // previous word is still pending and not being taken this cycle.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
`endif
    if (pub) begin
      out_d   = shreg_q;
      valid_d = 1'b1;
      fe_d    = pub_fe;
      ov_d    = valid_q & ~rx_ready;
`ifdef UART_RX_PARITY_EN
      pe_d    = par_p_q;
`endif
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shreg_q   <= '0;
      frame_p_q <= 1'b0;
      armed_q   <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      frame_p_q <= frame_p_d;
      armed_q   <= armed_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      par_p_q <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      par_p_q <= par_p_d;
      pe_q    <= pe_d;
    end
  end
  assign rx_parity_err = pe_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_out       = out_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = fe_q;
  assign rx_overrun   = ov_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: 16 clocks/bit, 8 data bits, 1 stop bit.
// Frames are built bit-by-bit from the serial format and the expected word,
// flags and publish cycle are derived from that format directly.
module tb_uart_rx_frame;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int ODD  = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB   = 1;
`else
  localparam int PB   = 0;
`endif
  localparam int HALF = (CPB - 1) / 2;
  localparam int NB   = 1 + DB + PB + SB;
  // 2 sync flops + the IDLE->START edge, then mid-point of the last stop bit.
  localparam int LAT  = 3 + (NB - 1) * CPB + HALF + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } word_t;

  logic          rx_clk = 1'b0;
  logic          rx_rst;
  logic          rx_in;
  logic          rx_ready;
  logic [DB-1:0] rx_out;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_overrun;
  logic          rx_busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (ODD)
  ) dut (
    .rx_clk        (rx_clk),
    .rx_rst        (rx_rst),
    .rx_in         (rx_in),
    .rx_ready      (rx_ready),
    .rx_out        (rx_out),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (ODD != 0);
  endfunction

  // Line bits in transmit order: start, data LSB first, [parity], stop(s).
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic par_bit,
                                           input logic stop_bit);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
    if (PB != 0) f[1+DB] = par_bit;
    for (int s = 0; s < SB; s++) f[1+DB+PB+s] = stop_bit;
    return f;
  endfunction

  task automatic drive_bits(input logic [15:0] f, input logic tail);
    for (int i = 0; i < NB; i++) begin
      rx_in = f[i];
      repeat (CPB) @(negedge rx_clk);
    end
    rx_in = tail;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"},   32'(rx_out), 32'h0);
    check({tag, ".valid"}, 32'(rx_valid), 32'h0);
    check({tag, ".fe"},    32'(rx_frame_err), 32'h0);
    check({tag, ".pe"},    32'(rx_parity_err), 32'h0);
    check({tag, ".ov"},    32'(rx_overrun), 32'h0);
    check({tag, ".busy"},  32'(rx_busy), 32'h0);
  endtask

  // One frame with a good stop bit and rx_ready=1: word, flags, publish
  // cycle and single-cycle valid pulse.
  task automatic xfer(input logic [7:0] d, input logic par_bit, input string tag);
    logic [15:0] f;
    logic [7:0]  w;
    logic        fe, pe, ov, v2, exp_pe;
    int          lat, c0;
    bit          got;
    f      = mk_frame(d, par_bit, 1'b1);
    exp_pe = (PB != 0) ? (par_bit != good_par(d)) : 1'b0;
    got = 0; lat = 0; w = '0; fe = 0; pe = 0; ov = 0; v2 = 0;
    c0 = cyc;
    fork
      drive_bits(f, 1'b1);
      begin
        for (int i = 0; i < CPB * (NB + 4) && !got; i++) begin
          @(negedge rx_clk);
          if (rx_valid) begin
            got = 1;
            lat = cyc - c0;
            w = rx_out; fe = rx_frame_err; pe = rx_parity_err; ov = rx_overrun;
            @(negedge rx_clk);
            v2 = rx_valid;
          end
        end
      end
    join
    check({tag, ".got"},   32'(got), 32'h1);
    check({tag, ".lat"},   32'(lat), 32'(LAT));
    check({tag, ".data"},  32'(w), 32'(d));
    check({tag, ".fe"},    32'(fe), 32'h0);
    check({tag, ".pe"},    32'(pe), 32'(exp_pe));
    check({tag, ".ov"},    32'(ov), 32'h0);
    check({tag, ".pulse"}, 32'(v2), 32'h0);
  endtask

  initial begin
    word_t q[$];
    int    c0, nv;
    logic [7:0] d;
    logic  p;

    rx_rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge rx_clk);
    check_zero("reset");
    rx_rst = 1'b0;
    repeat (4) @(negedge rx_clk);

    // Basic frame.
    xfer(8'hA5, good_par(8'hA5), "a5");

    // Back-to-back frames with no consumer: second overwrites first.
    rx_ready = 1'b0;
    drive_bits(mk_frame(8'h3C, good_par(8'h3C), 1'b1), 1'b1);
    check("ovr.first.valid", 32'(rx_valid), 32'h1);
    check("ovr.first.data",  32'(rx_out), 32'h3C);
    check("ovr.first.ov",    32'(rx_overrun), 32'h0);
    drive_bits(mk_frame(8'hC3, good_par(8'hC3), 1'b1), 1'b1);
    check("ovr.second.valid", 32'(rx_valid), 32'h1);
    check("ovr.second.data",  32'(rx_out), 32'hC3);
    check("ovr.second.ov",    32'(rx_overrun), 32'h1);
    check("ovr.second.fe",    32'(rx_frame_err), 32'h0);
    rx_ready = 1'b1;
    @(negedge rx_clk);
    check("ovr.accept.valid", 32'(rx_valid), 32'h0);
    check("ovr.accept.ov",    32'(rx_overrun), 32'h0);

    // One-cycle low glitch while idle.
    c0 = cyc; nv = 0;
    rx_in = 1'b0;
    @(negedge rx_clk);
    rx_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cyc == c0 + 10) check("glitch.busy_hi", 32'(rx_busy), 32'h1);
      if (cyc == c0 + 3 + HALF + 1) check("glitch.busy_lo", 32'(rx_busy), 32'h0);
      if (rx_valid) nv++;
      @(negedge rx_clk);
    end
    check("glitch.no_word", 32'(nv), 32'h0);

    // Stop bit forced low, then line held low (break), then released.
    q.delete();
    fork
      begin
        drive_bits(mk_frame(8'h55, good_par(8'h55), 1'b0), 1'b0);
        repeat (12 * CPB) @(negedge rx_clk);
        rx_in = 1'b1;
        repeat (4 * CPB) @(negedge rx_clk);
      end
      begin
        repeat ((NB + 16) * CPB) begin
          @(negedge rx_clk);
          if (rx_valid) q.push_back({rx_out, rx_frame_err, rx_parity_err, rx_overrun});
        end
      end
    join
    check("brk.count", 32'(q.size()), 32'h2);
    if (q.size() >= 1) begin
      check("brk.w0.data", 32'(q[0].d), 32'h55);
      check("brk.w0.fe",   32'(q[0].fe), 32'h1);
    end
    if (q.size() >= 2) begin
      check("brk.w1.data", 32'(q[1].d), 32'h00);
      check("brk.w1.fe",   32'(q[1].fe), 32'h1);
      check("brk.w1.pe",   32'(q[1].pe), 32'((PB != 0) && (ODD != 0)));
    end
    check("brk.idle", 32'(rx_busy), 32'h0);
    xfer(8'h5A, good_par(8'h5A), "rearm");

`ifdef UART_RX_PARITY_EN
    xfer(8'h07, 1'b0, "par.bad");
    xfer(8'h07, 1'b1, "par.good");
`endif

    // Reset in the middle of a frame; the partial word must vanish.
    nv = 0;
    fork
      drive_bits(mk_frame(8'hFF, 1'b1, 1'b1), 1'b1);
      begin
        repeat (4 * CPB) @(negedge rx_clk);
        check("rst.busy_before", 32'(rx_busy), 32'h1);
        rx_rst = 1'b1;
        @(negedge rx_clk);
        check_zero("rst.mid");
        @(negedge rx_clk);
        check_zero("rst.hold");
        rx_rst = 1'b0;
      end
      begin
        repeat (NB * CPB) begin
          @(negedge rx_clk);
          if (rx_valid) nv++;
        end
      end
    join
    check("rst.no_word", 32'(nv), 32'h0);
    repeat (2 * CPB) @(negedge rx_clk);
    xfer(8'h12, good_par(8'h12), "post_rst");

    // Randomised words with random idle gaps (and random bad parity when present).
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      p = good_par(d);
      if ((PB != 0) && ($urandom_range(0, 3) == 0)) p = ~p;
      repeat ($urandom_range(0, 20)) @(negedge rx_clk);
      xfer(d, p, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
